// File: rtl/seg_scan_pkg.sv
// Shared types and width helpers for the seven-segment digit scanner.
package seg_scan_pkg;

  typedef enum logic {
    S_ON  = 1'b0,
    S_GAP = 1'b1
  } state_t;

  // Widest scan index needed across the supported digit counts (2..16).
  localparam int MAX_DIGITS = 16;

  function automatic int idx_width(input int digits);
    return (digits <= 2) ? 1 : $clog2(digits);
  endfunction

  // The timer counts down from (phase length - 1), so it must hold max-1.
  function automatic int cnt_width(input int on_cycles, input int gap_cycles);
    int longest;
    longest = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
    return (longest <= 1) ? 1 : $clog2(longest);
  endfunction

  localparam int IDX_W = idx_width(MAX_DIGITS);

endpackage

// File: rtl/seg_scan_if.sv
// Data/control bundle between the scanner and its host/encoder.
interface seg_scan_if #(
  parameter int DIGITS = 8
);

  logic [4*DIGITS-1:0] i_data;
  logic                i_load;
  logic [DIGITS-1:0]   i_blank_mask;
  logic                i_lzb_en;
  logic [3:0]          o_num;
  logic [DIGITS-1:0]   o_dig_sel;
  logic                o_blank;
  logic                o_frame_done;
  logic                o_pending;

  modport master (
    output i_data, i_load, i_blank_mask, i_lzb_en,
    input  o_num, o_dig_sel, o_blank, o_frame_done, o_pending
  );

  modport slave (
    input  i_data, i_load, i_blank_mask, i_lzb_en,
    output o_num, o_dig_sel, o_blank, o_frame_done, o_pending
  );

endinterface

// File: rtl/seg_scan_lzb.sv
// Leading-zero blank vector: digit k is blanked when it and every more
// significant digit are zero; digit 0 is always kept so zero shows as "0".
module seg_scan_lzb
  import seg_scan_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic [4*DIGITS-1:0] disp_buf,
  input  logic                i_lzb_en,
  output logic [DIGITS-1:0]   lzb_vec
);

  logic all_zero;

  // Walk from the most significant digit down, accumulating "all zero so far".
  always_comb begin
    lzb_vec  = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero & (disp_buf[4*k +: 4] == 4'h0);
      lzb_vec[k] = i_lzb_en & all_zero;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with dead-time gaps,
// frame-boundary (tear-free) updates and optional leading-zero blanking.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int ON_CYCLES  = 50000,
  parameter int GAP_CYCLES = 500
) (
  input  logic       i_clk,
  input  logic       i_rst,
  seg_scan_if.slave  bus
);

  localparam int IW = idx_width(DIGITS);
  localparam int TW = cnt_width(ON_CYCLES, GAP_CYCLES);

  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  state_t              state;
  state_t              next_state;
  logic [IW-1:0]       idx;
  logic [TW-1:0]       timer;
  logic [4*DIGITS-1:0] pend_buf;
  logic [4*DIGITS-1:0] disp_buf;
  logic                pend_vld;
  logic                frame_done;

  logic                timer_done;
  logic                wrap;
  logic [DIGITS-1:0]   lzb_vec;
  logic [DIGITS-1:0]   dig_sel;
  logic                blank;
  logic [3:0]          num;

  assign timer_done = (timer == '0);
  // The gap before digit 0 is the only place a new word may take effect.
  assign wrap = (state == S_GAP) && timer_done && (idx == IDX_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_GAP;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_GAP:   if (timer_done) next_state = S_ON;
      S_ON:    if (timer_done) next_state = S_GAP;
      default: next_state = S_GAP;
    endcase
  end

  always_comb begin
    dig_sel = '1;
    blank   = 1'b1;
    if (state == S_ON) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx == IW'(k)) begin
          dig_sel[k] = 1'b0;
          blank      = bus.i_blank_mask[k] | lzb_vec[k];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx        <= IDX_LAST;
      timer      <= GAP_LOAD;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == S_ON) && timer_done && (idx == IDX_LAST);
      if (timer_done) begin
        if (state == S_GAP) begin
          timer <= ON_LOAD;
          idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          timer <= GAP_LOAD;
        end
      end else begin
        timer <= timer - 1'b1;
      end
    end
  end

  // A load coinciding with the boundary lands after the transfer, so it stays pending.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_buf <= '0;
      disp_buf <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (wrap && pend_vld) begin
        disp_buf <= pend_buf;
        pend_vld <= 1'b0;
      end
      if (bus.i_load) begin
        pend_buf <= bus.i_data;
        pend_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    num = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) num = disp_buf[4*k +: 4];
    end
  end

  seg_scan_lzb #(
    .DIGITS (DIGITS)
  ) u_lzb (
    .disp_buf (disp_buf),
    .i_lzb_en (bus.i_lzb_en),
    .lzb_vec  (lzb_vec)
  );

  assign bus.o_num        = num;
  assign bus.o_dig_sel    = dig_sel;
  assign bus.o_blank      = blank;
  assign bus.o_frame_done = frame_done;
  assign bus.o_pending    = pend_vld;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan (4 digits, 4 on / 2 gap cycles): a digit scoreboard
// filled per frame and popped as each digit lights, plus timing/reset sequences.
module tb_seg_scan;

  localparam int DIGITS = 4;
  localparam int ON     = 4;
  localparam int GAP    = 2;
  localparam int PERIOD = ON + GAP;
  localparam int FRAME  = DIGITS * PERIOD;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mask;
    logic        lzb;
    logic [15:0] exp_nums;
    logic [3:0]  exp_blank;
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] num;
    logic       blank;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [3:0] prev_sel = 4'hF;
  exp_t q[$];
  exp_t mon_e;
  vec_t vecs[6];
  vec_t v_two, v_x, v_y, v_zero;

  seg_scan_if #(.DIGITS(DIGITS)) bus();

  seg_scan #(
    .DIGITS     (DIGITS),
    .ON_CYCLES  (ON),
    .GAP_CYCLES (GAP)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, actual, required, n);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    n++;
  endtask

  task automatic waitPhase(input int p);
    while (n % FRAME != p) stepCycle();
  endtask

  task automatic applyStimulus(input logic [15:0] data);
    bus.i_data = data;
    bus.i_load = 1'b1;
    stepCycle();
    bus.i_load = 1'b0;
  endtask

  // Sets the live controls for the coming frame and queues its four digits.
  task automatic pushFrame(input vec_t v);
    logic [3:0] s;
    bus.i_blank_mask = v.mask;
    bus.i_lzb_en     = v.lzb;
    for (int k = 0; k < DIGITS; k++) begin
      s = 4'b0001 << k;
      q.push_back('{sel: ~s, num: v.exp_nums[4*k +: 4], blank: v.exp_blank[k]});
    end
    mon_en = 1'b1;
  endtask

  task automatic drainQueue();
    int budget;
    budget = 0;
    while (q.size() != 0 && budget < 3 * FRAME) begin
      stepCycle();
      budget++;
    end
    checkOutput("queue_drained", 16'(q.size()), 16'd0);
    mon_en = 1'b0;
  endtask

  // Compares each digit on its first lit cycle against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && mon_en && bus.o_dig_sel != 4'hF && prev_sel == 4'hF) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_digit: dig_sel=%b lit, required no pending digit", bus.o_dig_sel);
      end else begin
        mon_e = q.pop_front();
        checkOutput("sb_dig_sel", 16'(bus.o_dig_sel), 16'(mon_e.sel));
        checkOutput("sb_num", 16'(bus.o_num), 16'(mon_e.num));
        checkOutput("sb_blank", 16'(bus.o_blank), 16'(mon_e.blank));
      end
    end
    prev_sel = bus.o_dig_sel;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] exp_sel;
    int pos, dig;

    vecs[0] = '{data: 16'hA3C5, mask: 4'b0000, lzb: 1'b0, exp_nums: 16'hA3C5, exp_blank: 4'b0000};
    vecs[1] = '{data: 16'h0070, mask: 4'b0000, lzb: 1'b1, exp_nums: 16'h0070, exp_blank: 4'b1100};
    vecs[2] = '{data: 16'h0000, mask: 4'b0000, lzb: 1'b1, exp_nums: 16'h0000, exp_blank: 4'b1110};
    vecs[3] = '{data: 16'h1234, mask: 4'b0100, lzb: 1'b0, exp_nums: 16'h1234, exp_blank: 4'b0100};
    vecs[4] = '{data: 16'h1234, mask: 4'b0000, lzb: 1'b1, exp_nums: 16'h1234, exp_blank: 4'b0000};
    vecs[5] = '{data: 16'h0500, mask: 4'b0001, lzb: 1'b1, exp_nums: 16'h0500, exp_blank: 4'b1001};
    v_two   = '{data: 16'h2222, mask: 4'b0000, lzb: 1'b0, exp_nums: 16'h2222, exp_blank: 4'b0000};
    v_x     = '{data: 16'h4321, mask: 4'b0000, lzb: 1'b0, exp_nums: 16'h4321, exp_blank: 4'b0000};
    v_y     = '{data: 16'h8765, mask: 4'b0000, lzb: 1'b0, exp_nums: 16'h8765, exp_blank: 4'b0000};
    v_zero  = '{data: 16'h0000, mask: 4'b0000, lzb: 1'b0, exp_nums: 16'h0000, exp_blank: 4'b0000};

    bus.i_data       = '0;
    bus.i_load       = 1'b0;
    bus.i_blank_mask = '0;
    bus.i_lzb_en     = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_dig_sel", 16'(bus.o_dig_sel), 16'h000F);
    checkOutput("reset_blank", 16'(bus.o_blank), 16'd1);
    checkOutput("reset_num", 16'(bus.o_num), 16'd0);
    checkOutput("reset_frame_done", 16'(bus.o_frame_done), 16'd0);
    checkOutput("reset_pending", 16'(bus.o_pending), 16'd0);

    // Free-running scan with no load: gap/on rhythm and frame pulse.
    rst = 1'b0;
    n   = 0;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) stepCycle();
      pos = n % PERIOD;
      dig = (n % FRAME) / PERIOD;
      exp_sel = (pos < GAP) ? 4'hF : ~(4'b0001 << dig);
      checkOutput("free_dig_sel", 16'(bus.o_dig_sel), 16'(exp_sel));
      checkOutput("free_num", 16'(bus.o_num), 16'd0);
      checkOutput("free_blank", 16'(bus.o_blank), (pos < GAP) ? 16'd1 : 16'd0);
      checkOutput("free_frame_done", 16'(bus.o_frame_done), (n > 0 && n % FRAME == 0) ? 16'd1 : 16'd0);
    end

    // Table: load mid-frame, takes effect at the next frame only.
    for (int i = 0; i < 6; i++) begin
      waitPhase(12);
      applyStimulus(vecs[i].data);
      checkOutput("tbl_pending_set", 16'(bus.o_pending), 16'd1);
      waitPhase(1);
      checkOutput("tbl_pending_hold", 16'(bus.o_pending), 16'd1);
      pushFrame(vecs[i]);
      stepCycle();
      checkOutput("tbl_pending_clear", 16'(bus.o_pending), 16'd0);
    end

    // Two loads in one frame: only the last is ever shown.
    waitPhase(12);
    applyStimulus(16'h1111);
    waitPhase(16);
    applyStimulus(16'h2222);
    waitPhase(1);
    pushFrame(v_two);

    // Load on the boundary cycle: old pending word shows, new one stays pending.
    waitPhase(12);
    applyStimulus(v_x.data);
    waitPhase(1);
    pushFrame(v_x);
    applyStimulus(v_y.data);
    checkOutput("edge_pending_kept", 16'(bus.o_pending), 16'd1);
    waitPhase(1);
    checkOutput("edge_pending_hold", 16'(bus.o_pending), 16'd1);
    pushFrame(v_y);
    stepCycle();
    checkOutput("edge_pending_clear", 16'(bus.o_pending), 16'd0);

    // Reset while digit 2 is lit with a word pending.
    waitPhase(12);
    applyStimulus(16'h9999);
    waitPhase(15);
    checkOutput("pre_reset_dig_sel", 16'(bus.o_dig_sel), 16'h000B);
    checkOutput("pre_reset_pending", 16'(bus.o_pending), 16'd1);
    rst = 1'b1;
    #1;
    mon_en = 1'b0;
    q.delete();
    checkOutput("midrst_dig_sel", 16'(bus.o_dig_sel), 16'h000F);
    checkOutput("midrst_blank", 16'(bus.o_blank), 16'd1);
    checkOutput("midrst_num", 16'(bus.o_num), 16'd0);
    checkOutput("midrst_frame_done", 16'(bus.o_frame_done), 16'd0);
    checkOutput("midrst_pending", 16'(bus.o_pending), 16'd0);
    repeat (2) @(negedge clk);
    pushFrame(v_zero);
    rst = 1'b0;
    n   = 0;
    stepCycle();
    checkOutput("post_rst_gap", 16'(bus.o_dig_sel), 16'h000F);
    stepCycle();
    checkOutput("post_rst_dig_sel", 16'(bus.o_dig_sel), 16'h000E);
    checkOutput("post_rst_num", 16'(bus.o_num), 16'd0);
    checkOutput("post_rst_pending", 16'(bus.o_pending), 16'd0);
    drainQueue();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed scanner for a bank of common-anode seven-segment digits.
- Holds a double-buffered hex word, selects one digit at a time, and presents that digit's nibble to the downstream hex-to-seven-segment encoder, along with an active-low digit-select vector and a blank flag.
- Inserts an all-off dead-time gap between digits to suppress ghosting.
- Provides tear-free updates (applied only at frame boundaries) and optional leading-zero blanking.

Parameters:
- DIGITS, 8, number of digits scanned; legal 2..16.
- ON_CYCLES, 50000, clock cycles each digit is lit; must be >= 1.
- GAP_CYCLES, 500, clock cycles all digits are off between digits; must be >= 1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_data  in  4*DIGITS  hex word; digit k = i_data[4k+3:4k]; digit 0 is rightmost (least significant).
- i_load  in  1  one-cycle strobe; captures i_data into the pending buffer.
- i_blank_mask  in  DIGITS  bit k=1 forces digit k blank; sampled live.
- i_lzb_en  in  1  enables leading-zero blanking.
- o_num  out  4  nibble for the current digit; feeds the encoder input.
- o_dig_sel  out  DIGITS  active-low one-hot digit enable; all ones = all off.
- o_blank  out  1  1 = segment driver must force all segments off.
- o_frame_done  out  1  one-cycle pulse at the end of the last digit's ON phase.
- o_pending  out  1  1 = a loaded word is waiting for the next frame boundary.

Behaviour:
- Registers:
  - state {S_ON, S_GAP}.
  - idx, width clog2(DIGITS).
  - down-counter timer, width clog2(max(ON_CYCLES, GAP_CYCLES)).
  - pend_buf and disp_buf, each 4*DIGITS.
  - pend_vld and frame_done.
- Reset (async, immediate):
  - state=S_GAP, idx=DIGITS-1, timer=GAP_CYCLES-1.
  - disp_buf=0, pend_buf=0, pend_vld=0, frame_done=0.
  - Resulting outputs: o_dig_sel all ones, o_blank=1, o_num=0, o_frame_done=0, o_pending=0.
  - Reset mid-frame discards pending data.
- S_GAP:
  - o_dig_sel all ones, o_blank=1.
  - If timer==0: go to S_ON, idx = (idx==DIGITS-1) ? 0 : idx+1, timer=ON_CYCLES-1.
  - When idx wraps to 0 and pend_vld=1: disp_buf<=pend_buf and pend_vld<=0 in the same cycle.
  - Otherwise: timer-1.
- S_ON:
  - o_dig_sel = ~(1<<idx).
  - o_blank = i_blank_mask[idx] | lzb(idx).
  - If timer==0: go to S_GAP, timer=GAP_CYCLES-1; if idx==DIGITS-1, frame_done<=1 for exactly one cycle.
  - Otherwise: timer-1.
- o_num = disp_buf[4*idx+:4] in both states. It is Moore-style, derived from registers only.
- Period per digit = ON_CYCLES + GAP_CYCLES; frame = DIGITS × that.
- First digit 0 lights GAP_CYCLES cycles after reset release.
- lzb(k):
  - 1 iff i_lzb_en=1, k>=1, and every disp_buf nibble from k up to DIGITS-1 is 0.
  - Digit 0 is never LZB-blanked, so all-zero shows a single "0".
- Load:
  - i_load=1 → pend_buf<=i_data, pend_vld<=1.
  - Repeated loads before the boundary: last wins.
  - Load in the same cycle as the boundary transfer: the boundary moves the old pend_buf to disp_buf, and the new data stays pending with pend_vld=1.
- o_pending = pend_vld.
- The display never changes digit contents mid-frame.

Decomposition:
- Package seg_scan_pkg holds:
  - state enum (S_ON, S_GAP);
  - function computing counter width from ON_CYCLES/GAP_CYCLES;
  - localparam IDX_W.
- One natural combinational sub-module, seg_scan_lzb: inputs disp_buf and i_lzb_en, output DIGITS-bit leading-zero blank vector.
- The top indexes this vector with idx.

Test Plan (DIGITS=4, ON_CYCLES=4, GAP_CYCLES=2):
- Reset then release, no load:
  - o_dig_sel=4'b1111 for 2 cycles, then 4'b1110 for 4 cycles, then 4'b1111 for 2 cycles, then 4'b1101, and so on.
  - o_num=0 throughout.
  - o_frame_done pulses once per 24 cycles, after the 1110→0111 sequence.
- Load 16'hA3C5 mid-frame:
  - o_pending=1 until the next wrap to digit 0.
  - Next frame o_num per digit = 5, C, 3, A.
  - The current frame keeps the old values.
- i_lzb_en=1, load 16'h0070:
  - Digits 3 and 2 have o_blank=1 in S_ON.
  - Digit 1 shows o_num=7 with o_blank=0.
  - Digit 0 shows 0 with o_blank=0.
  - Load 16'h0000: only digit 0 is unblanked.
- Two loads (16'h1111 then 16'h2222) within one frame: the next frame displays 2222; 1111 is never displayed.
- i_blank_mask=4'b0100 with data 16'h1234: digit 2 has o_blank=1 during its ON phase, while o_dig_sel still walks 1011.
- Assert i_rst during S_ON of digit 2 with a pending load:
  - Outputs go immediately to the reset values.
  - After release, the first lit digit is 0 with o_num=0, and o_pending=0.
